// File: rtl/arm_core.sv
// Single-cycle ARMv4 subset core: fetch, execute and data-memory access all
// happen within one clock; register file, NZCV and PC are held internally.
module arm_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic [31:0] ReadData,
  output logic        MemWrite,
  output logic [31:0] PC,
  output logic [31:0] ALUResult,
  output logic [31:0] WriteData
);

  typedef enum logic [2:0] {CLS_NOP, CLS_DP, CLS_MUL, CLS_MEM, CLS_BR} cls_t;

  typedef enum logic [3:0] {
    OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
    OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
  } dp_op_t;

  logic [31:0] rf [0:14];
  logic [31:0] pc_q;
  logic [3:0]  nzcv;
  logic        flag_n, flag_z, flag_c, flag_v;

  logic [31:0] pc_plus4, pc_plus8;
  logic [31:0] rn_val, rd_val, rm_val, rs_val;
  cls_t        cls;
  dp_op_t      op;
  logic        cond_ok;

  logic [31:0] shift_out;
  logic        shift_c;
  logic [32:0] sh_wide;
  logic [5:0]  sh_amt;
  logic [4:0]  rot;

  logic [31:0] add_x, add_y;
  logic        add_cin, is_arith, add_v;
  logic [32:0] sum;
  logic [31:0] dp_res;

  logic [31:0] product, mem_addr, br_target;

  logic [31:0] alu_out, wr_data, pc_next;
  logic [3:0]  wr_idx, nzcv_next;
  logic        wr_en, br_take, mem_wr;

  assign {flag_n, flag_z, flag_c, flag_v} = nzcv;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;

  // R15 reads as PC+8; R0-R14 come straight from the register file.
  assign rn_val = (Instr[19:16] == 4'hF) ? pc_plus8 : rf[Instr[19:16]];
  assign rd_val = (Instr[15:12] == 4'hF) ? pc_plus8 : rf[Instr[15:12]];
  assign rm_val = (Instr[3:0]   == 4'hF) ? pc_plus8 : rf[Instr[3:0]];
  assign rs_val = (Instr[11:8]  == 4'hF) ? pc_plus8 : rf[Instr[11:8]];

  assign op        = dp_op_t'(Instr[24:21]);
  assign product   = rm_val * rs_val;
  assign mem_addr  = Instr[23] ? rn_val + {20'd0, Instr[11:0]}
                               : rn_val - {20'd0, Instr[11:0]};
  assign br_target = pc_plus8 + {{6{Instr[23]}}, Instr[23:0], 2'b00};

  // Instruction class decode; register-specified shifts fall through to NOP.
  always_comb begin
    cls = CLS_NOP;
    if (Instr[27:22] == 6'b000000 && Instr[7:4] == 4'b1001)
      cls = CLS_MUL;
    else if (Instr[27:26] == 2'b00 && (Instr[25] || !Instr[4]))
      cls = CLS_DP;
    else if (Instr[27:26] == 2'b01 && !Instr[25] && !Instr[22])
      cls = CLS_MEM;
    else if (Instr[27:25] == 3'b101)
      cls = CLS_BR;
  end

  // Condition field evaluation against current NZCV.
  always_comb begin
    case (Instr[31:28])
      4'h0:    cond_ok = flag_z;
      4'h1:    cond_ok = !flag_z;
      4'h2:    cond_ok = flag_c;
      4'h3:    cond_ok = !flag_c;
      4'h4:    cond_ok = flag_n;
      4'h5:    cond_ok = !flag_n;
      4'h6:    cond_ok = flag_v;
      4'h7:    cond_ok = !flag_v;
      4'h8:    cond_ok = flag_c && !flag_z;
      4'h9:    cond_ok = !flag_c || flag_z;
      4'hA:    cond_ok = (flag_n == flag_v);
      4'hB:    cond_ok = (flag_n != flag_v);
      4'hC:    cond_ok = !flag_z && (flag_n == flag_v);
      4'hD:    cond_ok = flag_z || (flag_n != flag_v);
      4'hE:    cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Operand-2 shifter; LSR/ASR carry is taken from a guard bit below the LSB.
  always_comb begin
    shift_out = rm_val;
    shift_c   = flag_c;
    sh_wide   = '0;
    rot       = {Instr[11:8], 1'b0};
    sh_amt    = (Instr[11:7] == 5'd0) ? 6'd32 : {1'b0, Instr[11:7]};
    if (Instr[25]) begin
      shift_out = ({24'd0, Instr[7:0]} >> rot) | ({24'd0, Instr[7:0]} << (6'd32 - {1'b0, rot}));
      if (Instr[11:8] != 4'd0) shift_c = shift_out[31];
    end else begin
      case (Instr[6:5])
        2'b00: if (Instr[11:7] != 5'd0) begin
          sh_wide   = {1'b0, rm_val} << Instr[11:7];
          shift_out = sh_wide[31:0];
          shift_c   = sh_wide[32];
        end
        2'b01: begin
          sh_wide   = {rm_val, 1'b0} >> sh_amt;
          shift_out = sh_wide[32:1];
          shift_c   = sh_wide[0];
        end
        2'b10: begin
          sh_wide   = 33'($signed({rm_val, 1'b0}) >>> sh_amt);
          shift_out = sh_wide[32:1];
          shift_c   = sh_wide[0];
        end
        default: if (Instr[11:7] != 5'd0) begin
          shift_out = (rm_val >> Instr[11:7]) | (rm_val << (6'd32 - {1'b0, Instr[11:7]}));
          shift_c   = shift_out[31];
        end
      endcase
    end
  end

  // Shared adder: subtraction is x + ~y + cin, so C comes out as NOT borrow.
  always_comb begin
    add_x    = rn_val;
    add_y    = shift_out;
    add_cin  = 1'b0;
    is_arith = 1'b1;
    case (op)
      OP_SUB, OP_CMP: begin add_y = ~shift_out; add_cin = 1'b1; end
      OP_RSB:         begin add_x = shift_out; add_y = ~rn_val; add_cin = 1'b1; end
      OP_ADD, OP_CMN: ;
      OP_ADC:         add_cin = flag_c;
      OP_SBC:         begin add_y = ~shift_out; add_cin = flag_c; end
      OP_RSC:         begin add_x = shift_out; add_y = ~rn_val; add_cin = flag_c; end
      default:        is_arith = 1'b0;
    endcase
    sum   = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    add_v = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
  end

  // Data-processing result selection.
  always_comb begin
    case (op)
      OP_AND, OP_TST: dp_res = rn_val & shift_out;
      OP_EOR, OP_TEQ: dp_res = rn_val ^ shift_out;
      OP_ORR:         dp_res = rn_val | shift_out;
      OP_MOV:         dp_res = shift_out;
      OP_BIC:         dp_res = rn_val & ~shift_out;
      OP_MVN:         dp_res = ~shift_out;
      default:        dp_res = sum[31:0];
    endcase
  end

  // Execute: register/flag/PC effects, all suppressed by a failed condition.
  always_comb begin
    alu_out   = '0;
    wr_en     = 1'b0;
    wr_idx    = Instr[15:12];
    wr_data   = '0;
    nzcv_next = nzcv;
    br_take   = 1'b0;
    mem_wr    = 1'b0;
    case (cls)
      CLS_DP: begin
        alu_out = dp_res;
        wr_data = dp_res;
        wr_en   = (Instr[24:23] != 2'b10);
        if (Instr[20] || Instr[24:23] == 2'b10)
          nzcv_next = {dp_res[31], dp_res == 32'd0,
                       is_arith ? sum[32] : shift_c,
                       is_arith ? add_v : flag_v};
      end
      CLS_MUL: begin
        alu_out = product;
        wr_data = product;
        wr_idx  = Instr[19:16];
        wr_en   = 1'b1;
        if (Instr[20]) nzcv_next = {product[31], product == 32'd0, flag_c, flag_v};
      end
      CLS_MEM: begin
        alu_out = mem_addr;
        if (Instr[20]) begin
          wr_en   = 1'b1;
          wr_data = ReadData;
        end else begin
          mem_wr = 1'b1;
        end
      end
      CLS_BR: begin
        alu_out = br_target;
        br_take = 1'b1;
        if (Instr[24]) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd14;
          wr_data = pc_plus4;
        end
      end
      default: ;
    endcase
    if (!cond_ok) begin
      wr_en     = 1'b0;
      nzcv_next = nzcv;
      br_take   = 1'b0;
      mem_wr    = 1'b0;
    end
    if (wr_en && wr_idx == 4'hF) pc_next = wr_data;
    else if (br_take)            pc_next = br_target;
    else                         pc_next = pc_plus4;
  end

  // Architectural state update; reset clears PC, R0-R14 and NZCV at once.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= '0;
      nzcv <= '0;
      for (int unsigned i = 0; i < 15; i++) rf[i] <= '0;
    end else begin
      pc_q <= pc_next;
      nzcv <= nzcv_next;
      if (wr_en && wr_idx != 4'hF) rf[wr_idx] <= wr_data;
    end
  end

  assign PC        = pc_q;
  assign ALUResult = alu_out;
  assign WriteData = rd_val;
  assign MemWrite  = mem_wr && RESET;

endmodule

// File: tb/tb_arm_core.sv
// Directed-program bench: each step pushes its expected outputs into a
// scoreboard queue; a monitor pops and compares on the falling edge.
module tb_arm_core;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] Instr = 32'hE1A00000;
  logic [31:0] ReadData = '0;
  logic        MemWrite;
  logic [31:0] PC, ALUResult, WriteData;

  arm_core dut (
    .CLK(CLK), .RESET(RESET), .Instr(Instr), .ReadData(ReadData),
    .MemWrite(MemWrite), .PC(PC), .ALUResult(ALUResult), .WriteData(WriteData)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic        chk_alu;
    logic [31:0] alu;
    logic        mw;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int          step_id = 0;
  logic [31:0] pc_exp = '0;

  task automatic chk(input string what, input int id, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL step%0d %s: got %h expected %h", id, what, got, want);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, sampled mid-cycle.
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("pc", mon_e.id, PC, mon_e.pc);
      chk("memwrite", mon_e.id, {31'd0, MemWrite}, {31'd0, mon_e.mw});
      if (mon_e.chk_alu) chk("aluresult", mon_e.id, ALUResult, mon_e.alu);
      if (mon_e.chk_wd)  chk("writedata", mon_e.id, WriteData, mon_e.wd);
    end
  end

  // Apply one instruction for one cycle; PC model: reset->0, jump->tgt, else +4.
  task automatic step(input logic [31:0] ins, input logic [31:0] rdata,
                      input logic ca, input logic [31:0] alu, input logic mw,
                      input logic cw, input logic [31:0] wd,
                      input logic jmp, input logic [31:0] tgt);
    exp_t e;
    Instr    = ins;
    ReadData = rdata;
    if (!RESET) pc_exp = '0;
    e.id = step_id; e.pc = pc_exp; e.chk_alu = ca; e.alu = alu;
    e.mw = mw; e.chk_wd = cw; e.wd = wd;
    sb.push_back(e);
    step_id++;
    pc_exp = !RESET ? 32'd0 : (jmp ? tgt : pc_exp + 32'd4);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    @(posedge CLK);
    #1;
    // Reset held
    RESET = 1'b0;
    repeat (3) step(32'hE1A00000, 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    // Loads through PC-relative addressing, then MUL / ADD / STR
    step(32'hE59F1204, 5, 1, 32'h20C, 0, 0, 0, 0, 0);
    step(32'hE59F2204, 6, 1, 32'h210, 0, 0, 0, 0, 0);
    step(32'hE59F9204, 3, 1, 32'h214, 0, 0, 0, 0, 0);
    step(32'hE0050291, 0, 1, 32'h1E,  0, 0, 0, 0, 0);
    step(32'hE0826009, 0, 1, 32'h9,   0, 0, 0, 0, 0);
    step(32'hE58C6000, 0, 1, 32'h0,   1, 1, 32'h9, 0, 0);
    // Branch-to-self holds PC
    step(32'hEAFFFFFE, 0, 0, 0, 0, 0, 0, 1, 32'h18);
    step(32'hEAFFFFFE, 0, 0, 0, 0, 0, 0, 1, 32'h18);
    // MOV / CMP equal, conditional execution on Z and C
    step(32'hE3A00005, 0, 1, 32'h5, 0, 0, 0, 0, 0);
    step(32'hE3500005, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(32'h12800001, 0, 0, 0,     0, 0, 0, 0, 0);
    step(32'h02800001, 0, 1, 32'h6, 0, 0, 0, 0, 0);
    step(32'hE1A0A000, 0, 1, 32'h6, 0, 0, 0, 0, 0);
    step(32'h158C6000, 0, 0, 0,     0, 0, 0, 0, 0);
    step(32'h258C6000, 0, 1, 32'h0, 1, 1, 32'h9, 0, 0);
    step(32'h358C6000, 0, 0, 0,     0, 0, 0, 0, 0);
    // MOVS of rotated immediate 0x80000000: N=1, Z=0
    step(32'hE3B01102, 0, 1, 32'h80000000, 0, 0, 0, 0, 0);
    step(32'h458C6000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(32'h058C6000, 0, 0, 0, 0, 0, 0, 0, 0);
    // BL +8: PC+16, R14 = PC+4
    step(32'hEB000002, 0, 0, 0, 0, 0, 0, 1, 32'h54);
    step(32'hE1A0300E, 0, 1, 32'h48, 0, 0, 0, 0, 0);
    step(32'hE58CE000, 0, 1, 32'h0,  1, 1, 32'h48, 0, 0);
    // ADDS overflow: 0x80000000+0x80000000 -> Z,C,V set, N clear
    step(32'hE0917001, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(32'h658C6000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(32'h458C6000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Immediate shifts: LSR #32, ASR #32, LSL #4, ROR #4
    step(32'hE1A08021, 0, 1, 32'h00000000, 0, 0, 0, 0, 0);
    step(32'hE1A08041, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    step(32'hE1A08206, 0, 1, 32'h00000090, 0, 0, 0, 0, 0);
    step(32'hE1A08266, 0, 1, 32'h90000000, 0, 0, 0, 0, 0);
    // CMP 6,#7: borrow (C=0), N=1 -> CC and LT true, GT false
    step(32'hE3500007, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    step(32'h358C6000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(32'hB58C6000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(32'hC58C6000, 0, 0, 0, 0, 0, 0, 0, 0);
    // Register-specified shift is a NOP; STR of R15 stores PC+8; NV never runs
    step(32'hE1A08116, 0, 0, 0, 0, 0, 0, 0, 0);
    step(32'hE58CF000, 0, 1, 32'h0, 1, 1, 32'h94, 0, 0);
    step(32'hF58C6000, 0, 0, 0, 0, 0, 0, 0, 0);
    // LDR into R15, then ADD into R15 (PC+8)
    step(32'hE59CF000, 32'h100, 1, 32'h0, 0, 0, 0, 1, 32'h100);
    step(32'hE28FF000, 0, 1, 32'h108, 0, 0, 0, 1, 32'h108);
    // Reset mid-program aborts MOV R0,#5 and clears state
    RESET = 1'b0;
    step(32'hE3A00005, 0, 0, 0, 0, 0, 0, 0, 0);
    RESET = 1'b1;
    step(32'hE1A0A000, 0, 1, 32'h0, 0, 0, 0, 0, 0);
    step(32'hE58C9000, 0, 1, 32'h0, 1, 1, 32'h0, 0, 0);
    step(32'h058C6000, 0, 0, 0, 0, 0, 0, 0, 0);
    step(32'h158C6000, 0, 0, 0, 1, 1, 32'h0, 0, 0);
    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
